// File: rtl/sram_waddr_gen.sv
// Write-address sequencer for the four result SRAM banks of the 16x16 systolic array.
// After a start pulse and a fixed latency, each bank gets a LEN-word write burst, skewed by SKEW per bank.
module sram_waddr_gen #(
  parameter int SKEW   = 4,
  parameter int LEN    = 99,
  parameter int LAT    = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sram_wen_0,
  output logic              sram_wen_1,
  output logic              sram_wen_2,
  output logic              sram_wen_3,
  output logic [ADDR_W-1:0] sram_waddr_0,
  output logic [ADDR_W-1:0] sram_waddr_1,
  output logic [ADDR_W-1:0] sram_waddr_2,
  output logic [ADDR_W-1:0] sram_waddr_3
);

  localparam int LAST   = LEN - 1 + 3 * SKEW;
  localparam int WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [WCNT_W-1:0]   w_wcnt_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;

  logic                w_wen_nx   [4];
  logic [ADDR_W-1:0]   w_waddr_nx [4];
  logic                w_done_nx;
  logic                r_wen_p1   [4];
  logic [ADDR_W-1:0]   r_waddr_p1 [4];
  logic                r_done_p1;

  function automatic logic in_win(input logic [CNT_W-1:0] cnt, input int g);
    return (cnt >= CNT_W'(SKEW * g)) && (cnt <= CNT_W'(SKEW * g + LEN - 1));
  endfunction

  // Difference taken in CNT_W bits; only consumed inside the window, so it never wraps visibly.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [CNT_W-1:0] cnt, input int g);
    logic [CNT_W-1:0] diff;
    diff = cnt - CNT_W'(SKEW * g);
    return ADDR_W'(diff);
  endfunction

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= w_wcnt_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wcnt_nx  = r_wcnt;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_WAIT;
          w_wcnt_nx  = '0;
        end
      end
      S_WAIT: begin
        if (r_wcnt == WCNT_W'(LAT - 1)) begin
          w_state_nx = S_WRITE;
          w_wcnt_nx  = '0;
          w_cnt_nx   = '0;
        end else begin
          w_wcnt_nx = r_wcnt + 1'b1;
        end
      end
      S_WRITE: begin
        if (r_cnt == CNT_W'(LAST)) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      w_wen_nx[g]   = 1'b0;
      w_waddr_nx[g] = '0;
      if ((r_state == S_WRITE) && in_win(r_cnt, g)) begin
        w_wen_nx[g]   = 1'b1;
        w_waddr_nx[g] = bank_addr(r_cnt, g);
      end
    end
    w_done_nx = (r_state == S_WRITE) && (r_cnt == CNT_W'(LAST));
  end

  // Stage p1: output flops, one cycle behind the sequence counter.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int g = 0; g < 4; g++) begin
        r_wen_p1[g]   <= 1'b0;
        r_waddr_p1[g] <= '0;
      end
      r_done_p1 <= 1'b0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        r_wen_p1[g]   <= w_wen_nx[g];
        r_waddr_p1[g] <= w_waddr_nx[g];
      end
      r_done_p1 <= w_done_nx;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done_p1;
  assign sram_wen_0   = r_wen_p1[0];
  assign sram_wen_1   = r_wen_p1[1];
  assign sram_wen_2   = r_wen_p1[2];
  assign sram_wen_3   = r_wen_p1[3];
  assign sram_waddr_0 = r_waddr_p1[0];
  assign sram_waddr_1 = r_waddr_p1[1];
  assign sram_waddr_2 = r_waddr_p1[2];
  assign sram_waddr_3 = r_waddr_p1[3];

endmodule

// File: tb/tb_sram_waddr_gen.sv
// Scoreboard bench for sram_waddr_gen: expected output vectors come from an edge-indexed
// timing model, are queued when start is driven, and are compared after each clock edge.
module tb_sram_waddr_gen;
  localparam int SKEW   = 4;
  localparam int LEN    = 99;
  localparam int LAT    = 16;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 7;
  localparam int LAST   = LEN - 1 + 3 * SKEW;
  localparam int RUN    = LAT + 1 + LAST;
  localparam int PW     = 6 + 4 * ADDR_W;

  logic              clk = 1'b0;
  logic              srstn;
  logic              start;
  logic              busy, done;
  logic              sram_wen_0, sram_wen_1, sram_wen_2, sram_wen_3;
  logic [ADDR_W-1:0] sram_waddr_0, sram_waddr_1, sram_waddr_2, sram_waddr_3;

  sram_waddr_gen #(
    .SKEW(SKEW), .LEN(LEN), .LAT(LAT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .busy(busy), .done(done),
    .sram_wen_0(sram_wen_0), .sram_wen_1(sram_wen_1),
    .sram_wen_2(sram_wen_2), .sram_wen_3(sram_wen_3),
    .sram_waddr_0(sram_waddr_0), .sram_waddr_1(sram_waddr_1),
    .sram_waddr_2(sram_waddr_2), .sram_waddr_3(sram_waddr_3)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] sb_q[$];
  int  n_chk    = 0;
  int  n_err    = 0;
  int  e_now    = 0;
  bit  act      = 1'b0;
  int  t0       = 0;
  int  done_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] dut_vec();
    return {busy, done, sram_wen_3, sram_wen_2, sram_wen_1, sram_wen_0,
            sram_waddr_3, sram_waddr_2, sram_waddr_1, sram_waddr_0};
  endfunction

  // Outputs expected right after edge t0+n for a run accepted at edge t0.
  function automatic logic [PW-1:0] model_vec(input bit a, input int n);
    logic              b, d;
    logic [3:0]        w;
    logic [ADDR_W-1:0] ad [4];
    int                first;
    b = 1'b0;
    d = 1'b0;
    w = '0;
    for (int g = 0; g < 4; g++) ad[g] = '0;
    if (a) begin
      b = (n >= 0) && (n < RUN);
      d = (n == RUN);
      for (int g = 0; g < 4; g++) begin
        first = LAT + 1 + SKEW * g;
        if (n >= first && n <= first + LEN - 1) begin
          w[g]  = 1'b1;
          ad[g] = ADDR_W'(n - first);
        end
      end
    end
    return {b, d, w[3], w[2], w[1], w[0], ad[3], ad[2], ad[1], ad[0]};
  endfunction

  task automatic step(input logic st, input string tag);
    int            e;
    logic [PW-1:0] exp_v;
    start = st;
    e = e_now + 1;
    if (st && (!act || e >= t0 + RUN + 1)) begin
      act = 1'b1;
      t0  = e;
    end
    sb_q.push_back(model_vec(act, e - t0));
    @(posedge clk);
    #1;
    e_now = e;
    exp_v = sb_q.pop_front();
    check_val(tag, 64'(dut_vec()), 64'(exp_v));
    if (done) done_cnt++;
  endtask

  initial begin
    srstn = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs", 64'(dut_vec()), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    #2 srstn = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b0, "idle");

    // Run 1: defaults, with stray start pulses at E5 and E60.
    done_cnt = 0;
    step(1'b1, "run1");
    for (int r = 1; r <= 135; r++) begin
      step((r == 5) || (r == 60), "run1");
      if (r == 16)  check_val("r1_wen0_pre",   64'(sram_wen_0), 64'd0);
      if (r == 17)  check_val("r1_wen0_first", 64'({sram_wen_0, sram_waddr_0}), 64'({1'b1, 10'd0}));
      if (r == 115) check_val("r1_wen0_last",  64'({sram_wen_0, sram_waddr_0}), 64'({1'b1, 10'd98}));
      if (r == 116) check_val("r1_wen0_post",  64'({sram_wen_0, sram_waddr_0}), 64'd0);
      if (r == 29)  check_val("r1_wen3_first", 64'({sram_wen_3, sram_waddr_3}), 64'({1'b1, 10'd0}));
      if (r == 127) check_val("r1_wen3_last",  64'({sram_wen_3, sram_waddr_3, done}), 64'({1'b1, 10'd98, 1'b1}));
      if (r == 126) check_val("r1_done_early", 64'(done), 64'd0);
      if (r == 128) check_val("r1_busy_fall",  64'(busy), 64'd0);
      if (r == 50)
        check_val("r1_overlap",
                  64'({sram_wen_3, sram_wen_2, sram_wen_1, sram_wen_0,
                       sram_waddr_0, sram_waddr_1, sram_waddr_2, sram_waddr_3}),
                  64'({4'b1111, 10'd33, 10'd29, 10'd25, 10'd21}));
    end
    check_val("r1_done_cnt", 64'(done_cnt), 64'd1);

    // Run 2: start held high through done, second run accepted in the done cycle.
    done_cnt = 0;
    step(1'b1, "run2");
    for (int r = 1; r <= 184; r++) begin
      step(r <= 130, "run2");
      if (r == 144) check_val("r2b_wen0_pre",   64'(sram_wen_0), 64'd0);
      if (r == 145) check_val("r2b_wen0_first", 64'({sram_wen_0, sram_waddr_0}), 64'({1'b1, 10'd0}));
      if (r == 184) check_val("r2b_mid_write",  64'({sram_wen_0, sram_waddr_0}), 64'({1'b1, 10'd39}));
    end
    check_val("r2_done_cnt", 64'(done_cnt), 64'd1);

    // Asynchronous reset in the middle of the second run's write phase.
    #2 srstn = 1'b0;
    #1;
    check_val("async_rst_outs", 64'(dut_vec()), 64'd0);
    act = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e_now = e_now + 2;
    check_val("rst_hold_outs", 64'(dut_vec()), 64'd0);
    #2 srstn = 1'b1;

    done_cnt = 0;
    for (int i = 0; i < 140; i++) step(1'b0, "post_rst");
    check_val("post_rst_done_cnt", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
